// File: rtl/ddr_dram_responder.sv
// Behavioural DRAM target: bank/row activate, 2-beat column bursts, CAS latency, refresh.
// Optional refresh-interval watchdog (REF_LIMIT, ref_violation) enabled by `define DRAM_REF_TIMEOUT_EN.
module ddr_dram_responder #(
  parameter int SIZE_OF_ROW = 64,
  parameter int N_ROW       = 64,
  parameter int N_BANK      = 4,
  parameter int DATA_W      = 8,
  parameter int CL          = 2,
  parameter int REF_CYCLES  = 8,
`ifdef DRAM_REF_TIMEOUT_EN
  parameter int REF_LIMIT   = 12500,
`endif
  localparam int COLS       = SIZE_OF_ROW / DATA_W,
  localparam int D_ADDR_W   = ($clog2(N_ROW) > $clog2(COLS)) ? $clog2(N_ROW) : $clog2(COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dram_ras,
  input  logic                dram_cas,
  input  logic                w_en,
  input  logic [D_ADDR_W-1:0] d_addr,
  input  logic                dram_dqs,
  inout  wire  [DATA_W-1:0]   dq,
  input  logic                refresh_request,
  output logic                ref_done,
  output logic                rd_valid,
  output logic                busy,
  output logic                protocol_err
`ifdef DRAM_REF_TIMEOUT_EN
  ,
  output logic                ref_violation
`endif
);

  localparam int BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int ROW_W  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int RW_W   = (CL > 2) ? $clog2(CL - 1) : 1;
  localparam int RF_W   = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ACT        = 3'd1;
  localparam logic [2:0] OPEN       = 3'd2;
  localparam logic [2:0] WRITE      = 3'd3;
  localparam logic [2:0] READ_WAIT  = 3'd4;
  localparam logic [2:0] READ_BURST = 3'd5;
  localparam logic [2:0] REFRESH    = 3'd6;

  logic [2:0]        state;
  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              beat;
  logic              ref_pend;
  logic [RW_W-1:0]   wait_cnt;
  logic [RF_W-1:0]   ref_cnt;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [COL_W-1:0]  col_k;
  logic [ADDR_W-1:0] addr;
  logic              ref_now;

  // Column wraps inside the open row; the bank/row fields never change mid-burst.
  assign col_k   = col + COL_W'(beat);
  assign addr    = {bank, row, col_k};
  assign ref_now = refresh_request | ref_pend;

  assign busy     = (state != IDLE);
  assign rd_valid = (state == READ_BURST);
  assign dq       = rd_valid ? mem[addr] : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bank         <= '0;
      row          <= '0;
      col          <= '0;
      beat         <= 1'b0;
      ref_pend     <= 1'b0;
      wait_cnt     <= '0;
      ref_cnt      <= '0;
      ref_done     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      ref_done     <= 1'b0;
      protocol_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_now) begin
            state    <= REFRESH;
            ref_pend <= 1'b0;
            ref_cnt  <= '0;
          end else if (dram_ras) begin
            bank  <= d_addr[BANK_W-1:0];
            state <= ACT;
          end
        end
        ACT: begin
          // A refresh arriving mid-activate is taken once the row is open.
          if (refresh_request) ref_pend <= 1'b1;
          if (dram_ras) begin
            row   <= d_addr[ROW_W-1:0];
            state <= OPEN;
          end else begin
            protocol_err <= 1'b1;
            state        <= IDLE;
          end
        end
        OPEN: begin
          if (ref_now) begin
            state    <= REFRESH;
            ref_pend <= 1'b0;
            ref_cnt  <= '0;
          end else if (dram_ras && dram_cas) begin
            protocol_err <= 1'b1;
          end else if (dram_cas) begin
            col      <= d_addr[COL_W-1:0];
            beat     <= 1'b0;
            wait_cnt <= '0;
            if (w_en)         state <= WRITE;
            else if (CL == 1) state <= READ_BURST;
            else              state <= READ_WAIT;
          end else if (dram_ras) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (refresh_request) ref_pend <= 1'b1;
          if (dram_dqs) begin
            beat <= 1'b1;
            if (beat) begin
              if (ref_now) begin
                state    <= REFRESH;
                ref_pend <= 1'b0;
                ref_cnt  <= '0;
              end else begin
                state <= OPEN;
              end
            end
          end
        end
        READ_WAIT: begin
          if (refresh_request) ref_pend <= 1'b1;
          if (wait_cnt == RW_W'(CL - 2)) state <= READ_BURST;
          else                           wait_cnt <= wait_cnt + RW_W'(1);
        end
        READ_BURST: begin
          if (refresh_request) ref_pend <= 1'b1;
          beat <= 1'b1;
          if (beat) begin
            if (ref_now) begin
              state    <= REFRESH;
              ref_pend <= 1'b0;
              ref_cnt  <= '0;
            end else begin
              state <= OPEN;
            end
          end
        end
        REFRESH: begin
          if (ref_cnt == RF_W'(REF_CYCLES - 1)) begin
            state    <= IDLE;
            ref_done <= 1'b1;
          end else begin
            ref_cnt <= ref_cnt + RF_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array contents survive reset by design.
  always_ff @(posedge clk) begin
    if (!reset && state == WRITE && dram_dqs) mem[addr] <= dq;
  end

`ifdef DRAM_REF_TIMEOUT_EN
  localparam int LIM_W = $clog2(REF_LIMIT + 1);
  logic [LIM_W-1:0] ref_age;

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_age       <= '0;
      ref_violation <= 1'b0;
    end else if (state == REFRESH) begin
      ref_age <= '0;
    end else if (ref_age == LIM_W'(REF_LIMIT)) begin
      ref_violation <= 1'b1;
    end else begin
      ref_age <= ref_age + LIM_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ddr_dram_responder.sv
// Directed bench for ddr_dram_responder with a model array and a read-data scoreboard queue.
module tb_ddr_dram_responder;

  localparam int CL         = 2;
  localparam int REF_CYCLES = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, dram_ras, dram_cas, w_en, dram_dqs, refresh_request;
  logic [5:0] d_addr;
  logic       tb_oe;
  logic [7:0] tb_dq;
  wire  [7:0] dq;
  logic       ref_done, rd_valid, busy, protocol_err;
`ifdef DRAM_REF_TIMEOUT_EN
  logic       ref_violation;
`endif

  assign dq = tb_oe ? tb_dq : 8'hzz;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model [4][64][8];
  logic [7:0] exp_q [$];
  int cur_bank, cur_row;

  ddr_dram_responder #(
    .SIZE_OF_ROW(64), .N_ROW(64), .N_BANK(4), .DATA_W(8), .CL(CL), .REF_CYCLES(REF_CYCLES)
`ifdef DRAM_REF_TIMEOUT_EN
    , .REF_LIMIT(20)
`endif
  ) dut (
    .clk(clk), .reset(reset), .dram_ras(dram_ras), .dram_cas(dram_cas), .w_en(w_en),
    .d_addr(d_addr), .dram_dqs(dram_dqs), .dq(dq), .refresh_request(refresh_request),
    .ref_done(ref_done), .rd_valid(rd_valid), .busy(busy), .protocol_err(protocol_err)
`ifdef DRAM_REF_TIMEOUT_EN
    , .ref_violation(ref_violation)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic activate(input int b, input int r);
    dram_ras = 1'b1;
    d_addr   = 6'(b);
    tick();
    check("act_busy", 32'(busy), 1);
    d_addr = 6'(r);
    tick();
    dram_ras = 1'b0;
    cur_bank = b;
    cur_row  = r;
  endtask

  task automatic precharge();
    dram_ras = 1'b1;
    d_addr   = 6'd0;
    tick();
    dram_ras = 1'b0;
    check("pre_idle", 32'(busy), 0);
  endtask

  // Two-beat write with an idle strobe cycle between the beats.
  task automatic write_burst(input int c, input logic [7:0] b0, input logic [7:0] b1, input logic req_ref);
    dram_cas = 1'b1;
    w_en     = 1'b1;
    d_addr   = 6'(c);
    tick();
    dram_cas        = 1'b0;
    w_en            = 1'b0;
    tb_oe           = 1'b1;
    dram_dqs        = 1'b1;
    tb_dq           = b0;
    refresh_request = req_ref;
    tick();
    refresh_request = 1'b0;
    dram_dqs        = 1'b0;
    tb_dq           = 8'hEE;
    tick();
    dram_dqs = 1'b1;
    tb_dq    = b1;
    tick();
    dram_dqs = 1'b0;
    tb_oe    = 1'b0;
    model[cur_bank][cur_row][c]           = b0;
    model[cur_bank][cur_row][(c + 1) % 8] = b1;
    check("wr_busy", 32'(busy), 1);
  endtask

  task automatic read_burst(input int c);
    int lat;
    dram_cas = 1'b1;
    w_en     = 1'b0;
    d_addr   = 6'(c);
    exp_q.push_back(model[cur_bank][cur_row][c]);
    exp_q.push_back(model[cur_bank][cur_row][(c + 1) % 8]);
    tick();
    dram_cas = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 12) begin
      tick();
      lat++;
    end
    check("rd_latency", lat, CL);
    if (rd_valid) begin
      for (int k = 0; k < 2; k++) begin
        check("rd_valid", 32'(rd_valid), 1);
        if (exp_q.size() > 0) check("rd_data", 32'(dq), 32'(exp_q.pop_front()));
        tick();
      end
      check("rd_done", 32'(rd_valid), 0);
      check("rd_open", 32'(busy), 1);
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic wait_ref_done();
    int n;
    n = 0;
    while (!ref_done && n < 40) begin
      dram_ras = (n == 2 || n == 3);
      tick();
      n++;
    end
    dram_ras = 1'b0;
    check("ref_len", n, REF_CYCLES);
    check("ref_idle", 32'(busy), 0);
    tick();
    check("ref_pulse", 32'(ref_done), 0);
    check("ref_stay_idle", 32'(busy), 0);
  endtask

  initial begin
    int n;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 8; c++)
          model[b][r][c] = 8'h00;
    reset = 1'b1; dram_ras = 1'b0; dram_cas = 1'b0; w_en = 1'b0; dram_dqs = 1'b0;
    refresh_request = 1'b0; d_addr = 6'd0; tb_oe = 1'b0; tb_dq = 8'h00;
    cur_bank = 0; cur_row = 0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_ref_done", 32'(ref_done), 0);
    check("rst_perr", 32'(protocol_err), 0);
    reset = 1'b0;
    tick();

    // Wrapping write and CL-timed read on bank 2 row 0x1A
    activate(2, 8'h1A);
    write_burst(7, 8'hAA, 8'h55, 1'b0);
    read_burst(7);

    // RAS and CAS together while open
    dram_ras = 1'b1; dram_cas = 1'b1; d_addr = 6'd0;
    tick();
    dram_ras = 1'b0; dram_cas = 1'b0;
    check("rascas_perr", 32'(protocol_err), 1);
    check("rascas_open", 32'(busy), 1);
    tick();
    check("rascas_perr_clr", 32'(protocol_err), 0);
    read_burst(7);
    write_burst(3, 8'h12, 8'h34, 1'b0);
    read_burst(3);
    precharge();

    // Activate without the second RAS beat
    dram_ras = 1'b1; d_addr = 6'd1;
    tick();
    dram_ras = 1'b0;
    tick();
    check("act_perr", 32'(protocol_err), 1);
    check("act_perr_idle", 32'(busy), 0);
    tick();
    check("act_perr_clr", 32'(protocol_err), 0);

    // Same row number in another bank must not alias
    activate(1, 8'h1A);
    write_burst(7, 8'hC3, 8'h3C, 1'b0);
    read_burst(7);
    precharge();
    activate(2, 8'h1A);
    read_burst(7);

    // Refresh requested during a write is taken after the second beat
    write_burst(4, 8'h5A, 8'hA5, 1'b1);
    wait_ref_done();
    activate(2, 8'h1A);
    read_burst(4);

    // Refresh beats CAS in OPEN, and RAS in IDLE
    refresh_request = 1'b1; dram_cas = 1'b1; w_en = 1'b0; d_addr = 6'd0;
    tick();
    refresh_request = 1'b0; dram_cas = 1'b0;
    check("ref_open_rd", 32'(rd_valid), 0);
    wait_ref_done();
    refresh_request = 1'b1; dram_ras = 1'b1; d_addr = 6'd3;
    tick();
    refresh_request = 1'b0; dram_ras = 1'b0;
    check("ref_idle_busy", 32'(busy), 1);
    wait_ref_done();

    // Reset in the middle of a read burst
    activate(2, 8'h1A);
    dram_cas = 1'b1; d_addr = 6'd7;
    tick();
    dram_cas = 1'b0;
    n = 1;
    while (!rd_valid && n < 12) begin
      tick();
      n++;
    end
    check("mid_rd_valid", 32'(rd_valid), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_perr", 32'(protocol_err), 0);
    reset = 1'b0;
    tick();

    // Array contents survive reset
    activate(2, 8'h1A);
    read_burst(7);
    precharge();

`ifdef DRAM_REF_TIMEOUT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("viol_before", 32'(ref_violation), 0);
    tick();
    check("viol_set", 32'(ref_violation), 1);
    refresh_request = 1'b1;
    tick();
    refresh_request = 1'b0;
    wait_ref_done();
    check("viol_sticky", 32'(ref_violation), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("viol_rst", 32'(ref_violation), 0);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
